// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage state encoding, per-stage field widths
// and control-field bit positions of the ID/EX latch.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_CTRL_W  = 11;
    localparam int unsigned IDEX_DATA_W  = 207;
    localparam int unsigned EXMEM_CTRL_W = 5;
    localparam int unsigned EXMEM_DATA_W = 107;
    localparam int unsigned MEMWB_CTRL_W = 2;
    localparam int unsigned MEMWB_DATA_W = 69;

    // ID/EX control layout: {RegWrite, MemToReg, MemWrite, MemRead, aluCtr[3:0], ALUSrcA, ALUSrcB, RegDst}
    localparam int unsigned CTRL_REGWRITE = 10;
    localparam int unsigned CTRL_MEMTOREG = 9;
    localparam int unsigned CTRL_MEMWRITE = 8;
    localparam int unsigned CTRL_MEMREAD  = 7;
    localparam int unsigned CTRL_ALUCTR_H = 6;
    localparam int unsigned CTRL_ALUCTR_L = 3;
    localparam int unsigned CTRL_ALUSRCA  = 2;
    localparam int unsigned CTRL_ALUSRCB  = 1;
    localparam int unsigned CTRL_REGDST   = 0;

    function automatic logic idex_has_write(input logic [IDEX_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer
// (main M drives outputs, skid S holds one extra) and synchronous flush.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W    = 11,
    parameter int unsigned DATA_W    = 207,
    parameter int unsigned ZERO_DATA = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [DATA_W-1:0] m_data_q, s_data_q;
    logic              accept, drain;
    logic              load_m_in, load_s_in, move_s_to_m;

    // Handshake flags decode only the state flops, so no ready path is combinational.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_s_in   = 1'b0;
        move_s_to_m = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_m_in = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_m_in = 1'b1;
                    end else if (accept) begin
                        load_s_in = 1'b1;
                        state_d   = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        move_s_to_m = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            if (load_m_in) begin
                m_ctrl_q <= in_ctrl;
                m_data_q <= in_data;
            end else if (move_s_to_m) begin
                m_ctrl_q <= s_ctrl_q;
                m_data_q <= s_data_q;
            end
            if (load_s_in) begin
                s_ctrl_q <= in_ctrl;
                s_data_q <= in_data;
            end
        end
    end

    // M is left untouched on flush/drain; the bubble is formed at the output instead.
    assign out_ctrl = out_valid ? m_ctrl_q : '0;
    assign out_data = ((ZERO_DATA != 0) && !out_valid) ? '0 : m_data_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .inc(out_valid && !out_ready && !flush),
        .clr(reset),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table on the default build plus
// hand sequences for counter saturation (CNT_W=3) and ZERO_DATA=0 hold.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default-parameter instance
    logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [10:0]  in_ctrl, out_ctrl;
    logic [206:0] in_data, out_data;
    logic [15:0]  stall_cnt;

    pipe_stage_skid u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    // Small saturating-counter instance
    logic       c_reset, c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [3:0] c_in_ctrl, c_out_ctrl;
    logic [7:0] c_in_data, c_out_data;
    logic [2:0] c_stall_cnt;

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(8), .ZERO_DATA(1), .CNT_W(3)) u_cnt (
        .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .stall_cnt(c_stall_cnt)
    );

    // Payload-holding instance
    logic       z_reset, z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
    logic [3:0] z_in_ctrl, z_out_ctrl;
    logic [7:0] z_in_data, z_out_data;
    logic [7:0] z_stall_cnt;

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(8), .ZERO_DATA(0), .CNT_W(8)) u_zd (
        .clk(clk), .reset(z_reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_ctrl(z_in_ctrl), .in_data(z_in_data), .flush(z_flush),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl),
        .out_data(z_out_data), .stall_cnt(z_stall_cnt)
    );

    typedef struct {
        logic        rst, iv, fl, ordy;
        logic [10:0] ctrl;
        logic [15:0] data;
        logic        e_ir, e_ov;
        logic [10:0] e_ctrl;
        logic [15:0] e_data;
        logic [15:0] e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic fl,
                                input logic ordy, input logic [10:0] ctrl,
                                input logic [15:0] data, input logic e_ir,
                                input logic e_ov, input logic [10:0] e_ctrl,
                                input logic [15:0] e_data, input logic [15:0] e_st);
        vec_t v;
        v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ctrl = ctrl; v.data = data;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        c_reset = 1'b1; c_in_valid = 1'b0; c_in_ctrl = '0; c_in_data = '0; c_flush = 1'b0; c_out_ready = 1'b0;
        z_reset = 1'b1; z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0; z_flush = 1'b0; z_out_ready = 1'b0;
        step();
        step();
        reset = 1'b0; c_reset = 1'b0; z_reset = 1'b0;

        check("reset in_ready",  256'(in_ready),  256'(1));
        check("reset out_valid", 256'(out_valid), 256'(0));
        check("reset out_ctrl",  256'(out_ctrl),  256'(0));
        check("reset out_data",  256'(out_data),  256'(0));
        check("reset stall_cnt", 256'(stall_cnt), 256'(0));

        //           rst  iv   fl   ordy ctrl     data   e_ir e_ov e_ctrl   e_data e_st
        vecs.push_back(mk(0, 1, 0, 1, 11'h7FF, 16'd5,  1, 1, 11'h7FF, 16'd5,  16'd0));
        vecs.push_back(mk(0, 0, 0, 1, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd0));
        // stream 1..4, one stall cycle
        vecs.push_back(mk(0, 1, 0, 1, 11'h011, 16'd1,  1, 1, 11'h011, 16'd1,  16'd0));
        vecs.push_back(mk(0, 1, 0, 0, 11'h012, 16'd2,  0, 1, 11'h011, 16'd1,  16'd1));
        vecs.push_back(mk(0, 1, 0, 1, 11'h013, 16'd3,  1, 1, 11'h012, 16'd2,  16'd1));
        vecs.push_back(mk(0, 1, 0, 1, 11'h013, 16'd3,  1, 1, 11'h013, 16'd3,  16'd1));
        vecs.push_back(mk(0, 1, 0, 1, 11'h014, 16'd4,  1, 1, 11'h014, 16'd4,  16'd1));
        vecs.push_back(mk(0, 0, 0, 1, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd1));
        // mid-run reset, then 5-cycle stall with upstream still offering
        vecs.push_back(mk(1, 0, 0, 0, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd0));
        vecs.push_back(mk(0, 1, 0, 1, 11'h01A, 16'd10, 1, 1, 11'h01A, 16'd10, 16'd0));
        vecs.push_back(mk(0, 1, 0, 0, 11'h02A, 16'd20, 0, 1, 11'h01A, 16'd10, 16'd1));
        vecs.push_back(mk(0, 1, 0, 0, 11'h03A, 16'd30, 0, 1, 11'h01A, 16'd10, 16'd2));
        vecs.push_back(mk(0, 1, 0, 0, 11'h03A, 16'd30, 0, 1, 11'h01A, 16'd10, 16'd3));
        vecs.push_back(mk(0, 1, 0, 0, 11'h03A, 16'd30, 0, 1, 11'h01A, 16'd10, 16'd4));
        vecs.push_back(mk(0, 1, 0, 0, 11'h03A, 16'd30, 0, 1, 11'h01A, 16'd10, 16'd5));
        vecs.push_back(mk(0, 1, 0, 1, 11'h03A, 16'd30, 1, 1, 11'h02A, 16'd20, 16'd5));
        vecs.push_back(mk(0, 1, 0, 1, 11'h03A, 16'd30, 1, 1, 11'h03A, 16'd30, 16'd5));
        vecs.push_back(mk(0, 0, 0, 1, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd5));
        // flush from TWO with value 9 offered; 9 must never surface
        vecs.push_back(mk(0, 1, 0, 0, 11'h04A, 16'd40, 1, 1, 11'h04A, 16'd40, 16'd5));
        vecs.push_back(mk(0, 1, 0, 0, 11'h05A, 16'd50, 0, 1, 11'h04A, 16'd40, 16'd6));
        vecs.push_back(mk(0, 1, 1, 0, 11'h009, 16'd9,  1, 0, 11'h000, 16'd0,  16'd6));
        vecs.push_back(mk(0, 0, 0, 1, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd6));
        // flush from ONE while the input would otherwise be accepted
        vecs.push_back(mk(0, 1, 0, 1, 11'h06A, 16'd60, 1, 1, 11'h06A, 16'd60, 16'd6));
        vecs.push_back(mk(0, 1, 1, 1, 11'h009, 16'd9,  1, 0, 11'h000, 16'd0,  16'd6));
        vecs.push_back(mk(0, 0, 0, 1, 11'h000, 16'd0,  1, 0, 11'h000, 16'd0,  16'd6));
        // reset beats flush and clears the counter
        vecs.push_back(mk(0, 1, 0, 0, 11'h07A, 16'd70, 1, 1, 11'h07A, 16'd70, 16'd6));
        vecs.push_back(mk(1, 1, 1, 0, 11'h009, 16'd9,  1, 0, 11'h000, 16'd0,  16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            in_valid  = vecs[i].iv;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            in_ctrl   = vecs[i].ctrl;
            in_data   = 207'(vecs[i].data);
            step();
            check($sformatf("v%0d in_ready", i),  256'(in_ready),  256'(vecs[i].e_ir));
            check($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].e_ov));
            check($sformatf("v%0d out_ctrl", i),  256'(out_ctrl),  256'(vecs[i].e_ctrl));
            check($sformatf("v%0d out_data", i),  256'(out_data),  256'(vecs[i].e_data));
            check($sformatf("v%0d stall_cnt", i), 256'(stall_cnt), 256'(vecs[i].e_st));
        end
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;

        // Saturation at 2^3-1 with a single held entry
        c_in_valid = 1'b1; c_in_ctrl = 4'h5; c_in_data = 8'h11; c_out_ready = 1'b1;
        step();
        check("cnt load out_valid", 256'(c_out_valid), 256'(1));
        check("cnt load out_data",  256'(c_out_data),  256'(8'h11));
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("cnt stall%0d", k), 256'(c_stall_cnt), 256'((k < 7) ? k : 7));
        end
        check("cnt hold out_valid", 256'(c_out_valid), 256'(1));
        check("cnt hold in_ready",  256'(c_in_ready),  256'(1));
        c_reset = 1'b1;
        step();
        c_reset = 1'b0;
        check("cnt reset stall_cnt", 256'(c_stall_cnt), 256'(0));
        check("cnt reset out_valid", 256'(c_out_valid), 256'(0));

        // ZERO_DATA=0: bubble zeroes control but keeps the last payload
        check("zd reset out_data", 256'(z_out_data), 256'(0));
        z_in_valid = 1'b1; z_in_ctrl = 4'hF; z_in_data = 8'hA5; z_out_ready = 1'b1;
        step();
        check("zd load out_ctrl", 256'(z_out_ctrl), 256'(4'hF));
        check("zd load out_data", 256'(z_out_data), 256'(8'hA5));
        z_in_valid = 1'b0;
        step();
        check("zd empty out_valid", 256'(z_out_valid), 256'(0));
        check("zd empty out_ctrl",  256'(z_out_ctrl),  256'(0));
        check("zd empty out_data",  256'(z_out_data),  256'(8'hA5));
        step();
        check("zd idle out_data",   256'(z_out_data),  256'(8'hA5));
        z_in_valid = 1'b1; z_in_ctrl = 4'h3; z_in_data = 8'h3C;
        step();
        z_in_valid = 1'b1; z_in_ctrl = 4'h6; z_in_data = 8'hEE; z_flush = 1'b1;
        step();
        z_in_valid = 1'b0; z_flush = 1'b0;
        check("zd flush out_valid", 256'(z_out_valid), 256'(0));
        check("zd flush out_ctrl",  256'(z_out_ctrl),  256'(0));
        check("zd flush out_data",  256'(z_out_data),  256'(8'h3C));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush. It is the generic successor to the fixed ID/EX latch and is placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure does not propagate combinationally: `in_ready` comes only from flops. A flushed or empty stage presents an all-zero bubble, so downstream stages see a NOP with no write enables asserted.

## Interface
- `CTRL_W`, default 11: width of the control field (WB/M/EX bits). Forced to zero whenever the output is a bubble.
- `DATA_W`, default 207: width of the payload field (PC+4, immediates, register indices, operands).
- `ZERO_DATA`, default 1: 1 = payload is also zeroed on a bubble; 0 = payload holds its last value (power saving).
- `CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage can accept; registered
- `in_ctrl`  in  CTRL_W  upstream control bits
- `in_data`  in  DATA_W  upstream payload
- `flush`  in  1  discard all held entries (branch/exception)
- `out_valid`  out  1  `out_ctrl`/`out_data` hold a real instruction
- `out_ready`  in  1  downstream accepts this cycle
- `out_ctrl`  out  CTRL_W  control to the next stage; 0 when `!out_valid`
- `out_data`  out  DATA_W  payload to the next stage
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`; saturating

## Operation
- Storage: main entry M drives the outputs; skid entry S holds one extra instruction.
- State encoding: EMPTY (no entries), ONE (M valid), TWO (M and S valid).
- Acceptance: accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered, so it is a pure function of the state flops.
- EMPTY:
  - accept: load M, go to ONE.
- ONE:
  - accept and drain: load M, stay in ONE.
  - accept, no drain: load S, go to TWO.
  - drain, no accept: go to EMPTY.
- TWO:
  - drain: S moves to M, go to ONE.
  - no drain: hold.
- Flush has top priority. In the next state is EMPTY and S is invalidated; any input presented in the same cycle is dropped, even if `in_valid && in_ready`.
- `reset` overrides flush and every other input.
- Bubble output: when the state is EMPTY, `out_valid`=0 and `out_ctrl`=0. `out_data`=0 if ZERO_DATA=1, otherwise last M contents.
- Order is preserved: S is always older than any new input, and nothing bypasses M.
- `stall_cnt`:
  - increments each cycle `out_valid && !out_ready` and no flush;
  - saturates at 2^CNT_W−1;
  - cleared only by `reset`.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0, S cleared.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle sustained while `out_ready`=1.
- A single downstream stall cycle is absorbed by S with no loss.
- After `out_ready` falls:
  - `in_ready` falls at the next edge, only if S filled.
  - `in_ready` rises one edge after the TWO→ONE drain.
- Flush at edge N: `out_valid`=0 and `out_ctrl`=0 from cycle N+1, and `in_ready`=1 from cycle N+1.
- Reset mid-operation behaves identically to flush and additionally clears `stall_cnt`.
- The upstream source must hold `in_ctrl`/`in_data` stable while `in_valid && !in_ready`. The stage does not check this.

## Structure
- Shared package `pipe_pkg`:
  - state encoding localparams `ST_EMPTY`, `ST_ONE`, `ST_TWO`;
  - the per-stage CTRL_W/DATA_W constants (ID/EX = 11/207 etc.);
  - control field bit positions (RegWrite, MemToReg, MemWrite, MemRead, aluCtr, ALUSrcA/B, RegDst).
- One sub-module: `sat_counter` (parameter CNT_W; inputs `inc`, `clr`; saturating).
- M and S are plain register arrays inside `pipe_stage_skid`.

## Test plan
- Reset, then `in_valid`=1, `in_ctrl`=0x7FF, `in_data`=5, `out_ready`=1 → `out_valid`=1, `out_ctrl`=0x7FF, `out_data`=5 one cycle later; `in_ready` stays 1.
- Stream data 1,2,3,4 with `out_ready` low for exactly one cycle mid-stream → outputs 1,2,3,4 in order with none lost; `in_ready` low for one cycle; `stall_cnt`=1.
- `out_ready`=0 for 5 cycles while upstream keeps offering → exactly 2 entries held; `in_ready`=0 from cycle 3; `stall_cnt`=5; release → the two held items emerge, then the held input.
- State TWO plus `flush` with `in_valid`=1 and data 9 → next cycle `out_valid`=0, `out_ctrl`=0, `out_data`=0 (ZERO_DATA=1), `in_ready`=1; value 9 never appears on the outputs.
- CNT_W=3, `out_ready`=0 for 10 cycles with `out_valid`=1 → `stall_cnt` sticks at 7; `reset` → 0.
- ZERO_DATA=0, drain to EMPTY → `out_ctrl`=0, `out_valid`=0, `out_data` retains the last value.
